accumulator_sequencer: RTL and testbench

Control-side counterpart of the combinational ALU. It accepts one AC-class instruction per handshake and owns the AC and E registers. It fetches the memory operand into DR when the instruction needs one, drives the ALU's one-hot operator lines and operands for exactly one cycle, and commits the ALU result and carry. It reports completion with a done pulse and the skip decision for the skip instructions.

---
 rtl/accumulator_sequencer.sv | 154 +++++++++++++++
 tb/tb_accumulator_sequencer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_sequencer.sv
// Sequencer for AC-class instructions: fetches the memory operand, drives the
// ALU operator lines for one EXEC cycle and commits the result into AC/E.
module accumulator_sequencer #(
  parameter int TIMEOUT = 15,
  parameter int TW      = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        cmd_valid_in,
  output logic        cmd_ready_out,
  input  logic [3:0]  cmd_op_in,
  output logic        mem_req_out,
  input  logic        mem_ack_in,
  input  logic [15:0] mem_data_in,
  output logic [15:0] alu_ac_out,
  output logic [15:0] alu_dr_out,
  output logic        alu_c_out,
  output logic        op_and_out,
  output logic        op_add_out,
  output logic        op_dr_out,
  output logic        op_inpr_out,
  output logic        op_complement_out,
  output logic        op_cir_out,
  output logic        op_cil_out,
  input  logic [15:0] alu_ac_in,
  input  logic        alu_c_in,
  output logic [15:0] ac_out,
  output logic        e_out,
  output logic        done_out,
  output logic        skip_out,
  output logic        error_out
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, DONE} state_t;

  localparam logic [3:0] OP_AND = 4'd1, OP_ADD = 4'd2, OP_LDA = 4'd3, OP_CLA = 4'd4;
  localparam logic [3:0] OP_CLE = 4'd5, OP_CMA = 4'd6, OP_CME = 4'd7, OP_CIR = 4'd8;
  localparam logic [3:0] OP_CIL = 4'd9, OP_INC = 4'd10, OP_SPA = 4'd11, OP_SNA = 4'd12;
  localparam logic [3:0] OP_SZA = 4'd13, OP_SZE = 4'd14, OP_INP = 4'd15;

  state_t        state_q, state_d;
  logic [15:0]   ac_q, ac_d, dr_q, dr_d;
  logic          e_q, e_d, skip_q, skip_d, err_q, err_d;
  logic [3:0]    op_q, op_d;
  logic [TW-1:0] cnt_q, cnt_d, cnt_inc;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      ac_q    <= '0;
      dr_q    <= '0;
      e_q     <= 1'b0;
      op_q    <= '0;
      cnt_q   <= '0;
      skip_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ac_q    <= ac_d;
      dr_q    <= dr_d;
      e_q     <= e_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
    end
  end

  assign cnt_inc    = cnt_q + TW'(1);
  assign alu_ac_out = ac_q;
  assign alu_c_out  = e_q;
  assign ac_out     = ac_q;
  assign e_out      = e_q;

  always_comb begin
    state_d           = state_q;
    ac_d              = ac_q;
    dr_d              = dr_q;
    e_d               = e_q;
    op_d              = op_q;
    cnt_d             = cnt_q;
    skip_d            = skip_q;
    err_d             = err_q;
    cmd_ready_out     = 1'b0;
    mem_req_out       = 1'b0;
    alu_dr_out        = '0;
    op_and_out        = 1'b0;
    op_add_out        = 1'b0;
    op_dr_out         = 1'b0;
    op_inpr_out       = 1'b0;
    op_complement_out = 1'b0;
    op_cir_out        = 1'b0;
    op_cil_out        = 1'b0;
    done_out          = 1'b0;
    skip_out          = 1'b0;
    error_out         = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_out = 1'b1;
        cnt_d         = '0;
        skip_d        = 1'b0;
        err_d         = 1'b0;
        if (cmd_valid_in) begin
          op_d    = cmd_op_in;
          state_d = (cmd_op_in inside {OP_AND, OP_ADD, OP_LDA}) ? FETCH : EXEC;
        end
      end
      FETCH: begin
        mem_req_out = 1'b1;
        cnt_d       = cnt_inc;
        // An ack on the limit cycle still wins over the timeout.
        if (mem_ack_in) begin
          dr_d    = mem_data_in;
          state_d = EXEC;
        end else if (TIMEOUT != 0 && cnt_inc == TW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      EXEC: begin
        state_d = DONE;
        case (op_q)
          OP_AND: begin op_and_out = 1'b1; alu_dr_out = dr_q; ac_d = alu_ac_in; end
          OP_ADD: begin
            op_add_out = 1'b1; alu_dr_out = dr_q; ac_d = alu_ac_in; e_d = alu_c_in;
          end
          OP_LDA: begin op_dr_out = 1'b1; alu_dr_out = dr_q; ac_d = alu_ac_in; end
          OP_CLA: ac_d = '0;
          OP_CLE: e_d = 1'b0;
          OP_CMA: begin op_complement_out = 1'b1; ac_d = alu_ac_in; end
          OP_CME: e_d = ~e_q;
          OP_CIR: begin op_cir_out = 1'b1; ac_d = alu_ac_in; e_d = alu_c_in; end
          OP_CIL: begin op_cil_out = 1'b1; ac_d = alu_ac_in; e_d = alu_c_in; end
          // INC reuses the adder with a constant operand but keeps E.
          OP_INC: begin op_add_out = 1'b1; alu_dr_out = 16'h0001; ac_d = alu_ac_in; end
          OP_SPA: skip_d = ~ac_q[15];
          OP_SNA: skip_d = ac_q[15];
          OP_SZA: skip_d = (ac_q == 16'h0000);
          OP_SZE: skip_d = ~e_q;
          OP_INP: begin op_inpr_out = 1'b1; ac_d = {8'h00, alu_ac_in[7:0]}; end
          default: ;
        endcase
      end
      DONE: begin
        done_out  = 1'b1;
        skip_out  = skip_q;
        error_out = err_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_accumulator_sequencer.sv
// Scoreboard bench for accumulator_sequencer with a behavioural ALU attached.
module tb_accumulator_sequencer;

  localparam int TO = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic        mem_req, mem_ack;
  logic [15:0] mem_data;
  logic [15:0] alu_ac_o, alu_dr_o, alu_ac_r;
  logic        alu_c_o, alu_c_r;
  logic        op_and, op_add, op_dr, op_inpr, op_comp, op_cir, op_cil;
  logic [15:0] ac;
  logic        e, done, skip, err;
  logic [7:0]  inpr;
  logic [6:0]  opvec;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_ac = 16'h0000;
  logic        model_e  = 1'b0;

  typedef struct {
    logic [15:0] ac;
    logic        e;
    logic        skip;
    logic        err;
    int          lat;
    int          memreq;
    logic [6:0]  opv;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  accumulator_sequencer #(.TIMEOUT(TO), .TW(4)) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .cmd_valid_in(cmd_valid), .cmd_ready_out(cmd_ready), .cmd_op_in(cmd_op),
    .mem_req_out(mem_req), .mem_ack_in(mem_ack), .mem_data_in(mem_data),
    .alu_ac_out(alu_ac_o), .alu_dr_out(alu_dr_o), .alu_c_out(alu_c_o),
    .op_and_out(op_and), .op_add_out(op_add), .op_dr_out(op_dr),
    .op_inpr_out(op_inpr), .op_complement_out(op_comp),
    .op_cir_out(op_cir), .op_cil_out(op_cil),
    .alu_ac_in(alu_ac_r), .alu_c_in(alu_c_r),
    .ac_out(ac), .e_out(e), .done_out(done), .skip_out(skip), .error_out(err)
  );

  assign opvec = {op_and, op_add, op_dr, op_inpr, op_comp, op_cir, op_cil};

  // Combinational ALU stand-in.
  always_comb begin
    alu_ac_r = alu_ac_o;
    alu_c_r  = alu_c_o;
    if (op_and) alu_ac_r = alu_ac_o & alu_dr_o;
    else if (op_add) {alu_c_r, alu_ac_r} = {1'b0, alu_ac_o} + {1'b0, alu_dr_o};
    else if (op_dr) alu_ac_r = alu_dr_o;
    else if (op_inpr) alu_ac_r = {8'h00, inpr};
    else if (op_comp) alu_ac_r = ~alu_ac_o;
    else if (op_cir) begin alu_ac_r = {alu_c_o, alu_ac_o[15:1]}; alu_c_r = alu_ac_o[0]; end
    else if (op_cil) begin alu_ac_r = {alu_ac_o[14:0], alu_c_o}; alu_c_r = alu_ac_o[15]; end
  end

  task automatic run_cmd(input logic [3:0] op, input int ack_at, input logic [15:0] data,
                         input string name);
    exp_t x, g;
    logic is_mem;
    int k, mreq, opcnt;
    logic [6:0] seen;
    logic got;
    is_mem   = (op inside {4'd1, 4'd2, 4'd3});
    x.ac     = model_ac;
    x.e      = model_e;
    x.skip   = 1'b0;
    x.err    = 1'b0;
    x.lat    = 2;
    x.memreq = 0;
    x.opv    = 7'b0;
    if (is_mem) begin
      if (ack_at == 0) begin
        x.err = 1'b1; x.lat = TO + 1; x.memreq = TO;
      end else begin
        x.lat = ack_at + 2; x.memreq = ack_at;
      end
    end
    if (!x.err) begin
      case (op)
        4'd1:  begin x.ac = model_ac & data; x.opv = 7'b1000000; end
        4'd2:  begin {x.e, x.ac} = {1'b0, model_ac} + {1'b0, data}; x.opv = 7'b0100000; end
        4'd3:  begin x.ac = data; x.opv = 7'b0010000; end
        4'd4:  x.ac = 16'h0000;
        4'd5:  x.e = 1'b0;
        4'd6:  begin x.ac = ~model_ac; x.opv = 7'b0000100; end
        4'd7:  x.e = ~model_e;
        4'd8:  begin x.ac = {model_e, model_ac[15:1]}; x.e = model_ac[0]; x.opv = 7'b0000010; end
        4'd9:  begin x.ac = {model_ac[14:0], model_e}; x.e = model_ac[15]; x.opv = 7'b0000001; end
        4'd10: begin x.ac = model_ac + 16'h0001; x.opv = 7'b0100000; end
        4'd11: x.skip = ~model_ac[15];
        4'd12: x.skip = model_ac[15];
        4'd13: x.skip = (model_ac == 16'h0000);
        4'd14: x.skip = ~model_e;
        4'd15: begin x.ac = {8'h00, inpr}; x.opv = 7'b0001000; end
        default: ;
      endcase
    end
    model_ac = x.ac;
    model_e  = x.e;
    sb.push_back(x);

    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    @(posedge clk);
    k = 0; mreq = 0; opcnt = 0; seen = 7'b0; got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      cmd_valid = 1'b0;
      mreq  += int'(mem_req);
      opcnt += $countones(opvec);
      seen  |= opvec;
      if (!done) begin
        checks++;
        if (skip !== 1'b0 || err !== 1'b0) begin
          errors++;
          $display("FAIL %s idle_flags skip=%b err=%b required 0/0", name, skip, err);
        end
      end else begin
        got = 1'b1;
        g = sb.pop_front();
        checks++;
        if (k != g.lat) begin errors++; $display("FAIL %s latency got %0d required %0d", name, k, g.lat); end
        checks++;
        if (skip !== g.skip) begin errors++; $display("FAIL %s skip got %b required %b", name, skip, g.skip); end
        checks++;
        if (err !== g.err) begin errors++; $display("FAIL %s error got %b required %b", name, err, g.err); end
        checks++;
        if (ac !== g.ac) begin errors++; $display("FAIL %s ac got %h required %h", name, ac, g.ac); end
        checks++;
        if (e !== g.e) begin errors++; $display("FAIL %s e got %b required %b", name, e, g.e); end
        checks++;
        if (mreq != g.memreq) begin errors++; $display("FAIL %s mem_req_cycles got %0d required %0d", name, mreq, g.memreq); end
        checks++;
        if (seen !== g.opv || opcnt != ((g.opv != 7'b0) ? 1 : 0)) begin
          errors++;
          $display("FAIL %s op_lines got %b x%0d required %b", name, seen, opcnt, g.opv);
        end
      end
      mem_ack  = is_mem && ack_at != 0 && k == ack_at;
      mem_data = mem_ack ? data : 16'hDEAD;
    end
    mem_ack = 1'b0;
    if (!got) begin
      errors++;
      checks++;
      $display("FAIL %s done_timeout got none required done within 40 cycles", name);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset cmd_ready got %b required 1", cmd_ready); end
    checks++;
    if ({mem_req, done, skip, err, e, opvec} !== 12'h0) begin
      errors++;
      $display("FAIL reset ctrl_outs got %b required 0", {mem_req, done, skip, err, e, opvec});
    end
    checks++;
    if (ac !== 16'h0 || alu_dr_o !== 16'h0) begin
      errors++; $display("FAIL reset ac/dr got %h/%h required 0000/0000", ac, alu_dr_o);
    end
    rst_n = 1'b1;
    model_ac = 16'h0000;
    model_e  = 1'b0;
  endtask

  task automatic test_add();
    run_cmd(4'd4, 0, 16'h0, "cla");
    run_cmd(4'd5, 0, 16'h0, "cle");
    run_cmd(4'd6, 0, 16'h0, "cma");
    run_cmd(4'd2, 2, 16'h0001, "add_carry");
  endtask

  task automatic test_rotate();
    run_cmd(4'd3, 1, 16'h8001, "lda_8001");
    run_cmd(4'd5, 0, 16'h0, "cle");
    run_cmd(4'd9, 0, 16'h0, "cil");
    run_cmd(4'd8, 0, 16'h0, "cir");
  endtask

  task automatic test_skip();
    run_cmd(4'd4, 0, 16'h0, "cla");
    run_cmd(4'd5, 0, 16'h0, "cle");
    run_cmd(4'd7, 0, 16'h0, "cme");
    run_cmd(4'd13, 0, 16'h0, "sza");
    run_cmd(4'd14, 0, 16'h0, "sze");
    run_cmd(4'd12, 0, 16'h0, "sna");
    run_cmd(4'd11, 0, 16'h0, "spa");
    run_cmd(4'd0, 0, 16'h0, "nop");
  endtask

  task automatic test_fetch_timeout();
    run_cmd(4'd3, TO, 16'h1234, "lda_ack_at_limit");
    run_cmd(4'd1, 1, 16'h00F0, "and");
    run_cmd(4'd3, 0, 16'hBEEF, "lda_timeout");
  endtask

  task automatic test_reset_abort();
    logic bad;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 4'd1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL abort fetch_req got %b required 1", mem_req); end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_ac = 16'h0000;
    model_e  = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++; $display("FAIL abort state req=%b ready=%b done=%b required 0/1/0", mem_req, cmd_ready, done);
    end
    checks++;
    if (ac !== 16'h0000) begin errors++; $display("FAIL abort ac got %h required 0000", ac); end
    mem_ack  = 1'b1;
    mem_data = 16'hFFFF;
    bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || mem_req !== 1'b0 || ac !== 16'h0000) bad = 1'b1;
    end
    mem_ack = 1'b0;
    checks++;
    if (bad) begin errors++; $display("FAIL abort late_ack got activity required none (ac=%h)", ac); end
  endtask

  task automatic test_back_to_back();
    logic exp_rdy, exp_done;
    run_cmd(4'd6, 0, 16'h0, "cma");
    run_cmd(4'd10, 0, 16'h0, "inc_wrap");
    inpr = 8'hA5;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 4'd15;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      exp_rdy  = (i % 3 == 0);
      exp_done = (i % 3 == 2);
      checks++;
      if (cmd_ready !== exp_rdy || done !== exp_done) begin
        errors++;
        $display("FAIL b2b cycle %0d ready/done got %b/%b required %b/%b", i, cmd_ready, done, exp_rdy, exp_done);
      end
    end
    cmd_valid = 1'b0;
    model_ac = 16'h00A5;
    @(negedge clk);
    checks++;
    if (ac !== model_ac || e !== model_e || cmd_ready !== 1'b1) begin
      errors++; $display("FAIL b2b final ac=%h e=%b ready=%b required %h/%b/1", ac, e, cmd_ready, model_ac, model_e);
    end
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = 4'd0;
    mem_ack   = 1'b0;
    mem_data  = 16'h0;
    inpr      = 8'h3C;
    rst_n     = 1'b0;
    test_reset();
    test_add();
    test_rotate();
    test_skip();
    test_fetch_timeout();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
